// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: RV32I byte/half/word loads and stores
// with a programmable wait-state FSM, alignment checking and error count.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            funct3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  ready,
    output logic                  misaligned,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] CNT_INIT =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic latch;

    logic                  l_rd, l_wr;
    logic [DM_ADDRESS-1:0] l_addr;
    logic [DATA_W-1:0]     l_wd;
    logic [2:0]            l_f3;

    logic                  c_rd, c_wr;
    logic [DM_ADDRESS-1:0] c_addr;
    logic [DATA_W-1:0]     c_wd;
    logic [2:0]            c_f3;
    logic                  fire;

    logic        legal, aligned, reject, we;
    logic [31:0] word, ld_val, st_lanes, new_word;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [3:0]  be;

    // Zero wait states serve the live inputs; otherwise the latched copy.
    always_comb begin
        if (WAIT_STATES == 0) begin
            c_rd   = MemRead;
            c_wr   = MemWrite;
            c_addr = addr;
            c_wd   = wr_data;
            c_f3   = funct3;
            fire   = (MemRead | MemWrite) & ~reset;
        end else begin
            c_rd   = l_rd;
            c_wr   = l_wr;
            c_addr = l_addr;
            c_wd   = l_wd;
            c_f3   = l_f3;
            fire   = (state == S_RESP) & ~reset;
        end
    end

    always_comb begin
        if (c_wr) begin
            legal = (c_f3 == 3'b000) || (c_f3 == 3'b001) || (c_f3 == 3'b010);
        end else begin
            legal = (c_f3[1:0] != 2'b11) && !(c_f3[2] && c_f3[1]);
        end
        case (c_f3[1:0])
            2'b01:   aligned = !c_addr[0];
            2'b10:   aligned = (c_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        reject = !legal || !aligned;
    end

    always_comb begin
        word = mem[c_addr[DM_ADDRESS-1:2]];
        ld_b = word[{c_addr[1:0], 3'b000} +: 8];
        ld_h = c_addr[1] ? word[31:16] : word[15:0];
        case (c_f3[1:0])
            2'b00:   ld_val = {{24{~c_f3[2] & ld_b[7]}}, ld_b};
            2'b01:   ld_val = {{16{~c_f3[2] & ld_h[15]}}, ld_h};
            default: ld_val = word;
        endcase
    end

    // Replicate store data across lanes, then pick lanes by byte enable.
    always_comb begin
        case (c_f3[1:0])
            2'b00: begin
                st_lanes = {4{c_wd[7:0]}};
                be       = 4'b0001 << c_addr[1:0];
            end
            2'b01: begin
                st_lanes = {2{c_wd[15:0]}};
                be       = c_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_lanes = c_wd;
                be       = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            new_word[8*i +: 8] = be[i] ? st_lanes[8*i +: 8] : word[8*i +: 8];
        end
        we = fire & c_wr & ~reject;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[c_addr[DM_ADDRESS-1:2]] <= new_word;
        end
    end

    assign ready      = fire;
    assign misaligned = fire & reject;
    assign rd_data    = (fire & ~reject & ~c_wr) ? ld_val : '0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if ((MemRead | MemWrite) && (WAIT_STATES != 0)) begin
                    latch   = 1'b1;
                    cnt_n   = CNT_INIT;
                    state_n = (WAIT_STATES == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_n = S_RESP;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_rd   <= 1'b0;
            l_wr   <= 1'b0;
            l_addr <= '0;
            l_wd   <= '0;
            l_f3   <= '0;
        end else if (latch) begin
            l_rd   <= MemRead;
            l_wr   <= MemWrite;
            l_addr <= addr;
            l_wd   <= wr_data;
            l_f3   <= funct3;
        end
    end

    // A rejected conflicting request still counts only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (fire && (reject || (c_rd && c_wr)) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with zero and three wait states.
module tb_dmem_responder;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_X  = 3'b011;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic [31:0] d;
        logic        m;
        int          c;
    } exp_t;

    logic clk;
    logic rst0, rst3;
    logic r0, w0, r3, w3;
    logic [8:0] a0, a3;
    logic [31:0] wd0, wd3;
    logic [2:0] fn0, fn3;
    logic [31:0] rd0, rd3;
    logic rdy0, rdy3, mis0, mis3;
    logic [7:0] ec0, ec3;

    int cyc;
    int checks;
    int errors;
    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;

    dmem_responder #(.WAIT_STATES(0)) d0 (
        .clk(clk), .reset(rst0), .MemRead(r0), .MemWrite(w0),
        .addr(a0), .wr_data(wd0), .funct3(fn0), .rd_data(rd0),
        .ready(rdy0), .misaligned(mis0), .err_count(ec0)
    );

    dmem_responder #(.WAIT_STATES(3)) d3 (
        .clk(clk), .reset(rst3), .MemRead(r3), .MemWrite(w3),
        .addr(a3), .wr_data(wd3), .funct3(fn3), .rd_data(rd3),
        .ready(rdy3), .misaligned(mis3), .err_count(ec3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rdy0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0_unexpected_ready cyc=%0d", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("d0_rd_data", rd0, e0.d);
                chk("d0_misaligned", {31'd0, mis0}, {31'd0, e0.m});
                chk("d0_ready_cycle", cyc, e0.c);
            end
        end
    end

    always @(negedge clk) begin
        if (rdy3) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d3_unexpected_ready cyc=%0d", cyc);
            end else begin
                e3 = q3.pop_front();
                chk("d3_rd_data", rd3, e3.d);
                chk("d3_misaligned", {31'd0, mis3}, {31'd0, e3.m});
                chk("d3_ready_cycle", cyc, e3.c);
            end
        end
    end

    task automatic op0(input logic rd, input logic wr, input logic [8:0] a,
                       input logic [31:0] wd, input logic [2:0] f,
                       input logic [31:0] ed, input logic em);
        r0 = rd; w0 = wr; a0 = a; wd0 = wd; fn0 = f;
        q0.push_back('{ed, em, cyc});
        @(posedge clk);
        #1;
        r0 = 1'b0; w0 = 1'b0;
    endtask

    task automatic op3(input logic rd, input logic wr, input logic [8:0] a,
                       input logic [31:0] wd, input logic [2:0] f,
                       input logic [31:0] ed, input logic em);
        r3 = rd; w3 = wr; a3 = a; wd3 = wd; fn3 = f;
        q3.push_back('{ed, em, cyc + 3});
        @(posedge clk);
        #1;
        r3 = 1'b0; w3 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        rst0 = 1'b1; rst3 = 1'b1;
        r0 = 0; w0 = 0; a0 = 0; wd0 = 0; fn0 = 0;
        r3 = 0; w3 = 0; a3 = 0; wd3 = 0; fn3 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {31'd0, rdy0}, 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_err0", {24'd0, ec0}, 32'd0);
        chk("rst_ready3", {31'd0, rdy3}, 32'd0);
        chk("rst_mis3", {31'd0, mis3}, 32'd0);
        @(posedge clk);
        #1;
        rst0 = 1'b0; rst3 = 1'b0;

        // zero-wait word and sub-word path
        op0(0, 1, 9'h010, 32'hDEADBEEF, F_W, 32'h0, 0);
        op0(1, 0, 9'h010, 32'h0, F_W, 32'hDEADBEEF, 0);
        op0(1, 0, 9'h013, 32'h0, F_B, 32'hFFFFFFDE, 0);
        op0(1, 0, 9'h013, 32'h0, F_BU, 32'h000000DE, 0);
        op0(1, 0, 9'h012, 32'h0, F_H, 32'hFFFFDEAD, 0);
        op0(0, 1, 9'h011, 32'h123456AA, F_B, 32'h0, 0);
        op0(1, 0, 9'h010, 32'h0, F_W, 32'hDEADAAEF, 0);
        op0(1, 0, 9'h010, 32'h0, F_HU, 32'h0000AAEF, 0);
        op0(0, 1, 9'h012, 32'h00007777, F_H, 32'h0, 0);
        op0(1, 0, 9'h010, 32'h0, F_W, 32'h7777AAEF, 0);

        // rejections and conflicts
        op0(1, 0, 9'h012, 32'h0, F_W, 32'h0, 1);
        chk("err_after_lw_mis", {24'd0, ec0}, 32'd1);
        op0(0, 1, 9'h013, 32'h0000BBBB, F_H, 32'h0, 1);
        chk("err_after_sh_mis", {24'd0, ec0}, 32'd2);
        op0(1, 0, 9'h010, 32'h0, F_W, 32'h7777AAEF, 0);
        op0(1, 0, 9'h010, 32'h0, F_X, 32'h0, 1);
        chk("err_after_f3_011", {24'd0, ec0}, 32'd3);
        op0(1, 1, 9'h030, 32'h0000CAFE, F_W, 32'h0, 0);
        chk("err_after_conflict", {24'd0, ec0}, 32'd4);
        op0(1, 0, 9'h030, 32'h0, F_W, 32'h0000CAFE, 0);
        op0(1, 1, 9'h031, 32'h11111111, F_W, 32'h0, 1);
        chk("err_conflict_reject", {24'd0, ec0}, 32'd5);
        op0(1, 0, 9'h030, 32'h0, F_W, 32'h0000CAFE, 0);
        for (int i = 0; i < 260; i++) begin
            op0(i[0], ~i[0], 9'h010, 32'h0, F_X, 32'h0, 1);
        end
        chk("err_saturated", {24'd0, ec0}, 32'd255);

        // three wait states: preload, then latency and ignored inputs
        op3(0, 1, 9'h040, 32'h0, F_W, 32'h0, 0);
        op3(0, 1, 9'h020, 32'h0, F_W, 32'h0, 0);
        op3(0, 1, 9'h010, 32'hDEADBEEF, F_W, 32'h0, 0);
        r3 = 1; w3 = 0; a3 = 9'h010; fn3 = F_W;
        q3.push_back('{32'hDEADBEEF, 1'b0, cyc + 3});
        @(posedge clk); #1;
        a3 = 9'h020;
        @(posedge clk); #1;
        r3 = 0;
        @(posedge clk); #1;
        w3 = 1; a3 = 9'h040; wd3 = 32'h55555555;
        @(posedge clk); #1;
        w3 = 0;
        op3(1, 0, 9'h010, 32'h0, F_W, 32'hDEADBEEF, 0);
        op3(1, 0, 9'h040, 32'h0, F_W, 32'h0, 0);
        op3(1, 0, 9'h012, 32'h0, F_W, 32'h0, 1);
        chk("d3_err_mis", {24'd0, ec3}, 32'd1);

        // reset while a store waits
        w3 = 1; a3 = 9'h020; wd3 = 32'h12345678; fn3 = F_W;
        @(posedge clk); #1;
        w3 = 0;
        @(posedge clk); #1;
        rst3 = 1;
        @(posedge clk); #1;
        rst3 = 0;
        chk("d3_err_after_reset", {24'd0, ec3}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        op3(1, 0, 9'h020, 32'h0, F_W, 32'h0, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("d0_queue_drained", q0.size(), 32'd0);
        chk("d3_queue_drained", q3.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
